// File: rtl/pb_pkg.sv
// Shared defaults, repeat-phase encoding and width helper for the push-button
// conditioner.
package pb_pkg;

    localparam int PB_N_BTN         = 3;
    localparam int PB_SYNC_STAGES   = 2;
    localparam int PB_STABLE_CNT    = 4;
    localparam int PB_REPEAT_DELAY  = 20;
    localparam int PB_REPEAT_PERIOD = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RPT
    } rpt_state_t;

    // Bits needed to hold values 0..max_val; never less than one.
    function automatic int pb_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One button channel: synchroniser, counter-based stability filter,
// press/release pulses and optional hold-to-repeat.
module pb_debounce_chan
    import pb_pkg::*;
#(
    parameter int SYNC_STAGES   = PB_SYNC_STAGES,
    parameter int STABLE_CNT    = PB_STABLE_CNT,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = PB_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = PB_REPEAT_PERIOD
) (
    input  logic slow_clk,
    input  logic RESET_N,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int CNT_W = pb_width(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   flip;
    logic                   rise;
    logic                   fall;

    assign s    = sync_q[SYNC_STAGES-1];
    assign flip = (s != o_level) && (cnt == CNT_LAST);
    assign rise = flip && s;
    assign fall = flip && !s;

    // NOTE: every piece of state, synchroniser included, clears on the async
    // reset so a mid-operation reset discards any half-seen input.
    always_ff @(posedge slow_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q    <= '0;
            cnt       <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every term below sees pre-edge values.
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_btn};
            o_press   <= rise;
            o_release <= fall;
            if (s == o_level) begin
                cnt <= '0;
            end else if (flip) begin
                o_level <= s;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    if (REPEAT_EN != 0) begin : g_repeat
        localparam int H_W = pb_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
        localparam logic [H_W-1:0] DLY_LAST = H_W'(REPEAT_DELAY - 1);
        localparam logic [H_W-1:0] PER_LAST = H_W'(REPEAT_PERIOD - 1);

        rpt_state_t     state;
        logic [H_W-1:0] h;

        // Release wins over any repeat due in the same cycle.
        always_ff @(posedge slow_clk or negedge RESET_N) begin
            if (!RESET_N) begin
                state    <= IDLE;
                h        <= '0;
                o_repeat <= 1'b0;
            end else begin
                o_repeat <= 1'b0;
                if (fall) begin
                    state <= IDLE;
                    h     <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            h <= '0;
                            if (rise) state <= WAIT;
                        end
                        WAIT: begin
                            if (h == DLY_LAST) begin
                                o_repeat <= 1'b1;
                                h        <= '0;
                                state    <= RPT;
                            end else begin
                                h <= h + 1'b1;
                            end
                        end
                        RPT: begin
                            if (h == PER_LAST) begin
                                o_repeat <= 1'b1;
                                h        <= '0;
                            end else begin
                                h <= h + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            h     <= '0;
                        end
                    endcase
                end
            end
        end
    end else begin : g_no_repeat
        assign o_repeat = 1'b0;
    end

endmodule

// File: rtl/pb_debounce_multi.sv
// N-channel push-button conditioner: per-channel debounce with press, release
// and auto-repeat pulses, plus a registered any-press summary.
module pb_debounce_multi
    import pb_pkg::*;
#(
    parameter int N_BTN         = PB_N_BTN,
    parameter int SYNC_STAGES   = PB_SYNC_STAGES,
    parameter int STABLE_CNT    = PB_STABLE_CNT,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = PB_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = PB_REPEAT_PERIOD
) (
    input  logic             slow_clk,
    input  logic             RESET_N,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat,
    output logic             o_any_press
);

    for (genvar k = 0; k < N_BTN; k++) begin : g_chan
        pb_debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CNT   (STABLE_CNT),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .slow_clk (slow_clk),
            .RESET_N  (RESET_N),
            .i_btn    (i_btn[k]),
            .o_level  (o_level[k]),
            .o_press  (o_press[k]),
            .o_release(o_release[k]),
            .o_repeat (o_repeat[k])
        );
    end

    // Lags the channel pulses by one cycle; same-cycle pulses merge.
    always_ff @(posedge slow_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            o_any_press <= 1'b0;
        end else begin
            o_any_press <= |(o_press | o_repeat);
        end
    end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Self-checking bench for pb_debounce_multi: edge-level model from the
// debounce/repeat rules plus directed scenarios with literal expectations.
module tb_pb_debounce_multi;

    localparam int N   = 3;
    localparam int SYN = 2;
    localparam int STB = 4;
    localparam int DLY = 20;
    localparam int PER = 5;

    logic           slow_clk;
    logic           RESET_N;
    logic [N-1:0]   i_btn;
    logic [N-1:0]   o_level;
    logic [N-1:0]   o_press;
    logic [N-1:0]   o_release;
    logic [N-1:0]   o_repeat;
    logic           o_any_press;

    int n_tests = 0;
    int n_fail  = 0;

    pb_debounce_multi #(
        .N_BTN        (N),
        .SYNC_STAGES  (SYN),
        .STABLE_CNT   (STB),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER)
    ) dut (
        .slow_clk   (slow_clk),
        .RESET_N    (RESET_N),
        .i_btn      (i_btn),
        .o_level    (o_level),
        .o_press    (o_press),
        .o_release  (o_release),
        .o_repeat   (o_repeat),
        .o_any_press(o_any_press)
    );

    initial begin
        slow_clk = 1'b0;
        forever #5 slow_clk = ~slow_clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level flips once the last STB synchronised samples all disagree with it;
    // repeats land at press + DLY + k*PER while the level stays high.
    logic [N-1:0] raw_q[$];
    logic [N-1:0] s_q[$];
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel   = '0;
    logic [N-1:0] m_rep   = '0;
    logic         m_any   = 1'b0;
    int           m_t     = 0;
    int           press_t[N];

    initial begin
        for (int k = 0; k < N; k++) press_t[k] = 0;
        forever begin
            @(posedge slow_clk or negedge RESET_N);
            if (!RESET_N) begin
                raw_q.delete();
                s_q.delete();
                m_level = '0;
                m_press = '0;
                m_rel   = '0;
                m_rep   = '0;
                m_any   = 1'b0;
            end else begin
                logic [N-1:0] cur_s;
                cur_s = (raw_q.size() >= SYN) ? raw_q[raw_q.size() - SYN] : '0;
                raw_q.push_back(i_btn);
                if (raw_q.size() > 8) void'(raw_q.pop_front());
                s_q.push_back(cur_s);
                if (s_q.size() > 16) void'(s_q.pop_front());
                m_any = |(m_press | m_rep);
                m_t++;
                for (int k = 0; k < N; k++) begin
                    bit stable;
                    bit rise;
                    int d;
                    stable = (s_q.size() >= STB);
                    if (stable) begin
                        for (int j = 0; j < STB; j++)
                            if (s_q[s_q.size() - 1 - j][k] == m_level[k]) stable = 0;
                    end
                    rise       = stable && !m_level[k];
                    m_press[k] = rise;
                    m_rel[k]   = stable && m_level[k];
                    if (stable) m_level[k] = ~m_level[k];
                    if (rise) press_t[k] = m_t;
                    d = m_t - press_t[k];
                    m_rep[k] = m_level[k] && !rise && (d >= DLY) && (((d - DLY) % PER) == 0);
                end
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge slow_clk) begin
        if (chk_en) begin
            check("model_level",   16'(o_level),     16'(m_level));
            check("model_press",   16'(o_press),     16'(m_press));
            check("model_release", 16'(o_release),   16'(m_rel));
            check("model_repeat",  16'(o_repeat),    16'(m_rep));
            check("model_any",     16'(o_any_press), 16'(m_any));
            check("press_rel_excl", 16'(o_press & o_release), 16'(0));
        end
    end

    // Advance n active edges; return 2 time units after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge slow_clk);
            #2;
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 16'({o_level, o_press, o_release, o_repeat, o_any_press}), 16'(0));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        RESET_N = 1'b0;
        i_btn   = '0;
        tick(3);
        chk_en = 1'b1;
        check_all_zero("reset_outputs");
        RESET_N = 1'b1;
        tick(2);

        // Clean press and release on channel 1.
        i_btn[0] = 1'b1;
        tick(5);
        check("clean_no_early_level", 16'(o_level[0]), 16'(0));
        tick(1);
        check("clean_level_rise", 16'(o_level[0]), 16'(1));
        check("clean_press", 16'(o_press), 16'(3'b001));
        tick(1);
        check("clean_press_one_cycle", 16'(o_press[0]), 16'(0));
        tick(5);
        i_btn[0] = 1'b0;
        tick(5);
        check("clean_release_not_yet", 16'(o_release[0]), 16'(0));
        tick(1);
        check("clean_release", 16'(o_release), 16'(3'b001));
        check("clean_level_fall", 16'(o_level[0]), 16'(0));
        check("clean_no_repeat", 16'(o_repeat), 16'(0));
        tick(3);

        // Bounce on channel 2: every excursion shorter than STB edges.
        for (int b = 0; b < 2; b++) begin
            i_btn[1] = 1'b1;
            tick(3);
            i_btn[1] = 1'b0;
            tick(2);
        end
        tick(8);
        check("bounce_level", 16'(o_level[1]), 16'(0));

        // Auto-repeat on channel 1; input dropped so the level falls at press+40.
        i_btn[0] = 1'b1;
        tick(6);
        check("rpt_press", 16'(o_press[0]), 16'(1));
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            check($sformatf("rpt_at_%0d", j), 16'(o_repeat[0]),
                  16'((j == 20) || (j == 25) || (j == 30) || (j == 35)));
            if (j == 34) i_btn[0] = 1'b0;
        end
        check("rpt_release_at_40", 16'(o_release[0]), 16'(1));
        for (int j = 0; j < 10; j++) begin
            tick(1);
            check("rpt_none_after_release", 16'(o_repeat[0]), 16'(0));
        end

        // Simultaneous channels 1 and 3.
        i_btn = 3'b101;
        tick(6);
        check("sim_press", 16'(o_press), 16'(3'b101));
        check("sim_any_lag", 16'(o_any_press), 16'(0));
        tick(1);
        check("sim_any_high", 16'(o_any_press), 16'(1));
        check("sim_press_done", 16'(o_press), 16'(0));
        tick(1);
        check("sim_any_one_cycle", 16'(o_any_press), 16'(0));

        // Near-threshold glitch on channel 3 at press+10..12.
        tick(8);
        i_btn[2] = 1'b0;
        tick(3);
        i_btn[2] = 1'b1;
        for (int j = 14; j <= 30; j++) begin
            tick(1);
            check($sformatf("glitch_rpt_%0d", j), 16'(o_repeat[2]),
                  16'((j == 20) || (j == 25) || (j == 30)));
            check("glitch_no_release", 16'(o_release[2]), 16'(0));
        end
        check("glitch_level_held", 16'(o_level[2]), 16'(1));

        // Async reset mid-repeat, then re-press with inputs still high.
        check("pre_reset_level1", 16'(o_level[0]), 16'(1));
        RESET_N = 1'b0;
        #1;
        check_all_zero("async_reset_clear");
        tick(2);
        check_all_zero("reset_held");
        RESET_N = 1'b1;
        tick(5);
        check("post_reset_wait", 16'(o_level), 16'(0));
        tick(1);
        check("post_reset_press", 16'(o_press), 16'(3'b101));

        i_btn = '0;
        tick(10);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
